// File: rtl/line_buffer_controller_if.sv
// Pixel input and line-buffer/matrix output bundle for line_buffer_controller.
// slave: controller side (drives O_*); master: pixel source / buffer side.
interface line_buffer_controller_if #(
  parameter int P_COLUMNS     = 640,
  parameter int P_IMAGE_ROWS  = 480,
  parameter int P_ROWS        = 3,
  parameter int P_PIXEL_DEPTH = 8
);
  logic [P_PIXEL_DEPTH-1:0]        I_PIXEL;
  logic                            I_PIXEL_VALID;
  logic                            O_PIXEL_READY;
  logic [$clog2(P_COLUMNS)-1:0]    O_FB_COLUMN;
  logic [$clog2(P_ROWS)-1:0]       O_FB_ROW;
  logic [P_PIXEL_DEPTH-1:0]        O_FB_PIXEL;
  logic                            O_FB_WRITE_ENABLE;
  logic                            O_FB_READ_ENABLE;
  logic                            O_MATRIX_VALID;
  logic [$clog2(P_COLUMNS)-1:0]    O_CENTER_COLUMN;
  logic [$clog2(P_IMAGE_ROWS)-1:0] O_CENTER_ROW;
  logic                            O_BORDER;
  logic                            O_FRAME_DONE;

  modport slave (
    input  I_PIXEL, I_PIXEL_VALID,
    output O_PIXEL_READY, O_FB_COLUMN, O_FB_ROW, O_FB_PIXEL,
    output O_FB_WRITE_ENABLE, O_FB_READ_ENABLE, O_MATRIX_VALID,
    output O_CENTER_COLUMN, O_CENTER_ROW, O_BORDER, O_FRAME_DONE
  );

  modport master (
    output I_PIXEL, I_PIXEL_VALID,
    input  O_PIXEL_READY, O_FB_COLUMN, O_FB_ROW, O_FB_PIXEL,
    input  O_FB_WRITE_ENABLE, O_FB_READ_ENABLE, O_MATRIX_VALID,
    input  O_CENTER_COLUMN, O_CENTER_ROW, O_BORDER, O_FRAME_DONE
  );
endinterface

// File: rtl/line_buffer_controller.sv
// Line-buffer controller: writes raster pixels into a P_ROWS-slot buffer and
// reads back the previous row to present 3-row matrix centres.
// Ports: I_CLK, I_RESET (sync, active high), bus (slave modport: pixel
// handshake in, buffer strobes/address/data and matrix centre out).
// Optional: LINE_BUFFER_CONTROLLER_FRAME_COUNT_EN adds O_FRAME_COUNT[15:0].
module line_buffer_controller #(
  parameter int P_COLUMNS     = 640,
  parameter int P_IMAGE_ROWS  = 480,
  parameter int P_ROWS        = 3,
  parameter int P_PIXEL_DEPTH = 8
) (
  input  logic I_CLK,
  input  logic I_RESET,
  line_buffer_controller_if.slave bus
`ifdef LINE_BUFFER_CONTROLLER_FRAME_COUNT_EN
  ,
  output logic [15:0] O_FRAME_COUNT
`endif
);
  localparam int CW = $clog2(P_COLUMNS);
  localparam int RW = $clog2(P_ROWS);
  localparam int IW = $clog2(P_IMAGE_ROWS);
  localparam int DW = P_PIXEL_DEPTH;
  localparam logic [CW-1:0] C_LAST = CW'(P_COLUMNS - 1);
  localparam logic [IW-1:0] R_LAST = IW'(P_IMAGE_ROWS - 1);
  localparam logic [RW-1:0] S_LAST = RW'(P_ROWS - 1);

  typedef enum logic [1:0] {
    S_ACCEPT, S_WRITE, S_READ, S_READ_LAST
  } state_t;

  state_t state_q, state_d;

  // Image position of the pixel currently in flight
  logic [CW-1:0] col_q, col_d;
  logic [IW-1:0] row_q, row_d;
  logic [RW-1:0] slot_q, slot_d;

  logic          ready_q, ready_d;
  logic [CW-1:0] fb_col_q, fb_col_d;
  logic [RW-1:0] fb_row_q, fb_row_d;
  logic [DW-1:0] fb_pix_q, fb_pix_d;
  logic          we_q, we_d;
  logic          re_q, re_d;
  logic          mv_q, mv_d;
  logic [CW-1:0] ctr_col_q, ctr_col_d;
  logic [IW-1:0] ctr_row_q, ctr_row_d;
  logic          border_q, border_d;
  logic          done_q, done_d;

  logic          hs;
  logic          last_col;
  logic          last_row;
  logic          advance;
  logic [RW-1:0] prev_slot;
  logic [CW-1:0] prev_col;

  always_comb begin
    hs        = bus.I_PIXEL_VALID & ready_q;
    last_col  = (col_q == C_LAST);
    last_row  = (row_q == R_LAST);
    prev_slot = (slot_q == '0) ? S_LAST : slot_q - RW'(1);
    prev_col  = col_q - CW'(1);

    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    slot_d    = slot_q;
    ready_d   = 1'b0;
    fb_col_d  = '0;
    fb_row_d  = '0;
    fb_pix_d  = '0;
    we_d      = 1'b0;
    re_d      = 1'b0;
    mv_d      = 1'b0;
    ctr_col_d = '0;
    ctr_row_d = '0;
    border_d  = 1'b0;
    done_d    = 1'b0;
    advance   = 1'b0;

    unique case (state_q)
      S_ACCEPT: begin
        // ready_q is low for the first cycle out of reset
        ready_d = 1'b1;
        if (hs) begin
          state_d  = S_WRITE;
          ready_d  = 1'b0;
          we_d     = 1'b1;
          fb_row_d = slot_q;
          fb_col_d = col_q;
          fb_pix_d = bus.I_PIXEL;
        end
      end
      S_WRITE: begin
        if (row_q >= IW'(2) && col_q != '0) begin
          state_d  = S_READ;
          re_d     = 1'b1;
          fb_row_d = prev_slot;
          fb_col_d = prev_col;
        end else begin
          advance = 1'b1;
        end
      end
      S_READ: begin
        mv_d      = 1'b1;
        ctr_row_d = row_q - IW'(1);
        ctr_col_d = prev_col;
        border_d  = (prev_col == '0);
        if (last_col) begin
          state_d  = S_READ_LAST;
          re_d     = 1'b1;
          fb_row_d = prev_slot;
          fb_col_d = C_LAST;
        end else begin
          advance = 1'b1;
        end
      end
      S_READ_LAST: begin
        mv_d      = 1'b1;
        ctr_row_d = row_q - IW'(1);
        ctr_col_d = C_LAST;
        border_d  = 1'b1;
        advance   = 1'b1;
      end
      default: ;
    endcase

    // Pixel finished: step to next raster position
    if (advance) begin
      state_d = S_ACCEPT;
      ready_d = 1'b1;
      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d  = '0;
          slot_d = '0;
          done_d = 1'b1;
        end else begin
          row_d  = row_q + IW'(1);
          slot_d = (slot_q == S_LAST) ? '0 : slot_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q   <= S_ACCEPT;
      col_q     <= '0;
      row_q     <= '0;
      slot_q    <= '0;
      ready_q   <= 1'b0;
      fb_col_q  <= '0;
      fb_row_q  <= '0;
      fb_pix_q  <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      mv_q      <= 1'b0;
      ctr_col_q <= '0;
      ctr_row_q <= '0;
      border_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      slot_q    <= slot_d;
      ready_q   <= ready_d;
      fb_col_q  <= fb_col_d;
      fb_row_q  <= fb_row_d;
      fb_pix_q  <= fb_pix_d;
      we_q      <= we_d;
      re_q      <= re_d;
      mv_q      <= mv_d;
      ctr_col_q <= ctr_col_d;
      ctr_row_q <= ctr_row_d;
      border_q  <= border_d;
      done_q    <= done_d;
    end
  end

  assign bus.O_PIXEL_READY     = ready_q;
  assign bus.O_FB_COLUMN       = fb_col_q;
  assign bus.O_FB_ROW          = fb_row_q;
  assign bus.O_FB_PIXEL        = fb_pix_q;
  assign bus.O_FB_WRITE_ENABLE = we_q;
  assign bus.O_FB_READ_ENABLE  = re_q;
  assign bus.O_MATRIX_VALID    = mv_q;
  assign bus.O_CENTER_COLUMN   = ctr_col_q;
  assign bus.O_CENTER_ROW      = ctr_row_q;
  assign bus.O_BORDER          = border_q;
  assign bus.O_FRAME_DONE      = done_q;

`ifdef LINE_BUFFER_CONTROLLER_FRAME_COUNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = done_d ? fcnt_q + 16'd1 : fcnt_q;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) fcnt_q <= '0;
    else         fcnt_q <= fcnt_d;
  end

  assign O_FRAME_COUNT = fcnt_q;
`endif
endmodule

// File: tb/tb_line_buffer_controller.sv
// Self-checking bench for line_buffer_controller (4x4 image, 3 buffer rows).
// Per-pixel transaction model builds the expected per-cycle output stream.
module tb_line_buffer_controller;
  localparam int C  = 4;
  localparam int IR = 4;
  localparam int PR = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_buffer_controller_if #(
    .P_COLUMNS(C), .P_IMAGE_ROWS(IR), .P_ROWS(PR), .P_PIXEL_DEPTH(DW)
  ) lbif ();

`ifdef LINE_BUFFER_CONTROLLER_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  line_buffer_controller #(
    .P_COLUMNS(C), .P_IMAGE_ROWS(IR), .P_ROWS(PR), .P_PIXEL_DEPTH(DW)
  ) dut (
    .I_CLK(clk),
    .I_RESET(rst),
    .bus(lbif)
`ifdef LINE_BUFFER_CONTROLLER_FRAME_COUNT_EN
    ,
    .O_FRAME_COUNT(frame_count)
`endif
  );

  typedef struct {
    bit rdy, we, re, mv, bd, dn;
    int row, col, pix, crow, ccol;
  } rec_t;

  int checks = 0;
  int failures = 0;

  rec_t exp_q[$];
  rec_t cur;
  int   n_pix = 0;
  int   fcnt = 0;
  int   acc_cnt = 0;
  int   cyc = 0;
  bit   rst_e;
  bit   cur_read1 = 0;

  int ws[$], wc[$], wp[$], wcyc[$];
  int rcyc[$];
  int mr[$], mc[$], mb[$], mcyc[$];
  int dcnt = 0;

  int exp_slot[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic rec_t zrec();
    rec_t t;
    t = '{default: 0};
    return t;
  endfunction

  // Expected outputs for one accepted pixel, cycle by cycle
  task automatic schedule(int pix);
    int   r, c;
    int   cols[$];
    rec_t t;
    r = n_pix / C;
    c = n_pix % C;
    if (r >= 2 && c >= 1) begin
      cols.push_back(c - 1);
      if (c == C - 1) cols.push_back(C - 1);
    end
    t = zrec();
    t.we = 1; t.row = r % PR; t.col = c; t.pix = pix;
    exp_q.push_back(t);
    for (int i = 0; i <= cols.size(); i++) begin
      t = zrec();
      if (i < cols.size()) begin
        t.re = 1; t.row = (r + PR - 1) % PR; t.col = cols[i];
      end else begin
        t.rdy = 1;
      end
      if (i > 0) begin
        t.mv = 1; t.crow = r - 1; t.ccol = cols[i-1];
        t.bd = (cols[i-1] == 0) || (cols[i-1] == C - 1);
      end
      if (i == cols.size() && n_pix == C * IR - 1) t.dn = 1;
      exp_q.push_back(t);
    end
    n_pix = (n_pix + 1) % (C * IR);
  endtask

  // Compare process: model vs DUT every cycle
  always begin
    @(posedge clk);
    rst_e = rst;
    cyc++;
    @(negedge clk);
    if (rst_e) begin
      cur = zrec();
      exp_q.delete();
      n_pix = 0;
      fcnt = 0;
      ws.delete(); wc.delete(); wp.delete(); wcyc.delete();
      rcyc.delete();
      mr.delete(); mc.delete(); mb.delete(); mcyc.delete();
      dcnt = 0;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else begin
      cur = zrec();
      cur.rdy = 1;
    end
    if (cur.dn) fcnt = (fcnt + 1) % 65536;
    cur_read1 = cur.re && !cur.mv;

    chk("ready", 32'(lbif.O_PIXEL_READY), 32'(cur.rdy));
    chk("write_en", 32'(lbif.O_FB_WRITE_ENABLE), 32'(cur.we));
    chk("read_en", 32'(lbif.O_FB_READ_ENABLE), 32'(cur.re));
    chk("matrix_valid", 32'(lbif.O_MATRIX_VALID), 32'(cur.mv));
    chk("frame_done", 32'(lbif.O_FRAME_DONE), 32'(cur.dn));
    if (cur.we || cur.re) begin
      chk("fb_row", 32'(lbif.O_FB_ROW), cur.row);
      chk("fb_col", 32'(lbif.O_FB_COLUMN), cur.col);
    end
    if (cur.we) chk("fb_pixel", 32'(lbif.O_FB_PIXEL), cur.pix);
    if (cur.mv) begin
      chk("center_row", 32'(lbif.O_CENTER_ROW), cur.crow);
      chk("center_col", 32'(lbif.O_CENTER_COLUMN), cur.ccol);
      chk("border", 32'(lbif.O_BORDER), 32'(cur.bd));
    end
`ifdef LINE_BUFFER_CONTROLLER_FRAME_COUNT_EN
    chk("frame_count", 32'(frame_count), fcnt);
`endif

    if (!rst_e) begin
      if (lbif.O_FB_WRITE_ENABLE === 1'b1) begin
        ws.push_back(int'(lbif.O_FB_ROW));
        wc.push_back(int'(lbif.O_FB_COLUMN));
        wp.push_back(int'(lbif.O_FB_PIXEL));
        wcyc.push_back(cyc);
      end
      if (lbif.O_FB_READ_ENABLE === 1'b1) rcyc.push_back(cyc);
      if (lbif.O_MATRIX_VALID === 1'b1) begin
        mr.push_back(int'(lbif.O_CENTER_ROW));
        mc.push_back(int'(lbif.O_CENTER_COLUMN));
        mb.push_back(int'(lbif.O_BORDER));
        mcyc.push_back(cyc);
      end
      if (lbif.O_FRAME_DONE === 1'b1) dcnt++;
    end

    if (!rst && cur.rdy && lbif.I_PIXEL_VALID) begin
      schedule(int'(lbif.I_PIXEL));
      acc_cnt++;
    end
  end

  // mode 0: pixel = index, 1: random, 2: fixed value
  task automatic drive(int npix, int pct, int mode, int val);
    int target = acc_cnt + npix;
    int guard = 0;
    while (acc_cnt < target && guard < 4000) begin
      @(posedge clk); #1;
      guard++;
      if (acc_cnt >= target) break;
      lbif.I_PIXEL_VALID = ($urandom_range(99) < pct);
      case (mode)
        0:       lbif.I_PIXEL = DW'(acc_cnt);
        1:       lbif.I_PIXEL = DW'($urandom);
        default: lbif.I_PIXEL = DW'(val);
      endcase
    end
    lbif.I_PIXEL_VALID = 1'b0;
    chk("drive_timeout", 32'(acc_cnt >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    lbif.I_PIXEL_VALID = 1'b0;
    lbif.I_PIXEL = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Full frame plus one pixel, valid held high
    drive(17, 100, 0, 0);
    repeat (6) @(posedge clk);
    for (int i = 0; i < 8; i++) chk("first_slots", at(ws, i), exp_slot[i]);
    chk("p8_slot", at(ws, 8), 2);
    chk("p9_slot", at(ws, 9), 2);
    chk("p9_col", at(wc, 9), 1);
    chk("p9_read_lat", at(rcyc, 0) - at(wcyc, 9), 1);
    chk("p9_valid_lat", at(mcyc, 0) - at(rcyc, 0), 1);
    chk("v0_row", at(mr, 0), 1);
    chk("v0_col", at(mc, 0), 0);
    chk("v0_border", at(mb, 0), 1);
    chk("p11_b2b", at(rcyc, 3) - at(rcyc, 2), 1);
    chk("v2_col", at(mc, 2), 2);
    chk("v2_border", at(mb, 2), 0);
    chk("v3_col", at(mc, 3), 3);
    chk("v3_border", at(mb, 3), 1);
    chk("frame_valids", mcyc.size(), 8);
    chk("frame_dones", dcnt, 1);
    chk("next_frame_slot", at(ws, 16), 0);
    chk("next_frame_col", at(wc, 16), 0);
    chk("next_frame_pix", at(wp, 16), 16);
`ifdef LINE_BUFFER_CONTROLLER_FRAME_COUNT_EN
    chk("frame_count_lit", 32'(frame_count), 1);
`endif

    // Random valid toggling and data
    drive(45, 50, 1, 0);
    repeat (6) @(posedge clk);

    // Reset while in the first read state
    @(posedge clk); #1;
    lbif.I_PIXEL_VALID = 1'b1;
    lbif.I_PIXEL = 8'hAA;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #1;
      if (cur_read1) found = 1;
    end
    chk("read_state_seen", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("abort_no_valid", 32'(lbif.O_MATRIX_VALID), 32'd0);
    chk("abort_ready_low", 32'(lbif.O_PIXEL_READY), 32'd0);
    lbif.I_PIXEL_VALID = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 100, 2, 8'h55);
    repeat (6) @(posedge clk);
    chk("post_rst_slot", at(ws, 0), 0);
    chk("post_rst_col", at(wc, 0), 0);
    chk("post_rst_pix", at(wp, 0), 32'h55);
    chk("post_rst_valids", mcyc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/line_buffer_controller.md
LINE_BUFFER_CONTROLLER -- requirements
Module: line_buffer_controller

Interface
REQ-001 SHALL have parameter P_COLUMNS, default 640, meaning pixels per image row and buffer columns.
REQ-002 SHALL have parameter P_IMAGE_ROWS, default 480, meaning rows per frame.
REQ-003 SHALL have parameter P_ROWS, default 3, meaning buffer rows.
REQ-004 SHALL have parameter P_PIXEL_DEPTH, default 8, meaning bits per pixel.
REQ-005 SHALL have port I_CLK, input, 1, the single clock; all logic rising-edge.
REQ-006 SHALL have port I_RESET, input, 1, synchronous active-high reset.
REQ-007 SHALL have port I_PIXEL, input, P_PIXEL_DEPTH, raster-order input pixel.
REQ-008 SHALL have port I_PIXEL_VALID, input, 1, I_PIXEL holds a valid pixel.
REQ-009 SHALL have port O_PIXEL_READY, output, 1, controller accepts I_PIXEL this cycle.
REQ-010 SHALL have port O_FB_COLUMN, output, $clog2(P_COLUMNS), buffer column address.
REQ-011 SHALL have port O_FB_ROW, output, $clog2(P_ROWS), buffer row slot.
REQ-012 SHALL have port O_FB_PIXEL, output, P_PIXEL_DEPTH, buffer write data.
REQ-013 SHALL have ports O_FB_WRITE_ENABLE and O_FB_READ_ENABLE, outputs, 1 each, buffer strobes.
REQ-014 SHALL have port O_MATRIX_VALID, output, 1, buffer O_PIXEL_MATRIX valid this cycle.
REQ-015 SHALL have ports O_CENTER_COLUMN and O_CENTER_ROW, outputs, $clog2(P_COLUMNS) and $clog2(P_IMAGE_ROWS), image coordinates of the valid matrix centre.
REQ-016 SHALL have port O_BORDER, output, 1, centre column is 0 or P_COLUMNS-1.
REQ-017 SHALL have port O_FRAME_DONE, output, 1, one-cycle end-of-frame pulse.

Function
REQ-018 SHALL implement FSM states S_ACCEPT, S_WRITE, S_READ, S_READ_LAST; all outputs registered.
REQ-019 SHALL assert O_PIXEL_READY only in S_ACCEPT; handshake = I_PIXEL_VALID & O_PIXEL_READY; no handshake holds S_ACCEPT.
REQ-020 SHALL on handshake capture I_PIXEL and move to S_WRITE.
REQ-021 SHALL in S_WRITE assert O_FB_WRITE_ENABLE for exactly one cycle with O_FB_ROW = r mod P_ROWS, O_FB_COLUMN = c, where (r,c) is the captured pixel's image position.
REQ-022 SHALL from S_WRITE go to S_READ if r >= 2 and c >= 1, else to S_ACCEPT.
REQ-023 SHALL in S_READ assert O_FB_READ_ENABLE one cycle, O_FB_ROW = (r-1) mod P_ROWS, O_FB_COLUMN = c-1; next S_READ_LAST if c = P_COLUMNS-1, else S_ACCEPT.
REQ-024 SHALL in S_READ_LAST assert O_FB_READ_ENABLE one cycle with O_FB_ROW = (r-1) mod P_ROWS, O_FB_COLUMN = P_COLUMNS-1; next S_ACCEPT.
REQ-025 SHALL never assert O_FB_WRITE_ENABLE and O_FB_READ_ENABLE in the same cycle.
REQ-026 SHALL assert O_MATRIX_VALID exactly one cycle after each read-enable cycle, with O_CENTER_ROW/O_CENTER_COLUMN/O_BORDER describing that read's centre.
REQ-027 SHALL emit centres for image rows 1..P_IMAGE_ROWS-2, all columns; exactly (P_IMAGE_ROWS-2)*P_COLUMNS valids per frame.
REQ-028 SHALL advance c after each write; wrap c to 0 and increment r after c = P_COLUMNS-1; row slot wraps P_ROWS-1 to 0.
REQ-029 SHALL after the final state of pixel (P_IMAGE_ROWS-1, P_COLUMNS-1) pulse O_FRAME_DONE one cycle, reset r, c, slot to 0, start next frame without gap.
REQ-030 SHALL have throughput 1 pixel per 2 cycles (no read), 3 (one read), 4 (row end).

Reset
REQ-031 SHALL on I_RESET force S_ACCEPT, r = c = slot = 0, discard captured pixel and pending reads.
REQ-032 SHALL hold all outputs 0 during reset, including O_PIXEL_READY; O_PIXEL_READY = 1 first cycle after release.
REQ-033 SHALL, on reset mid-read, produce no O_MATRIX_VALID for the aborted read.

Configuration
REQ-034 SHALL, with LINE_BUFFER_CONTROLLER_FRAME_COUNT_EN defined, add output O_FRAME_COUNT, 16 bits, reset 0, incremented with each O_FRAME_DONE, wrapping 0xFFFF to 0.
REQ-035 SHALL, without LINE_BUFFER_CONTROLLER_FRAME_COUNT_EN, omit O_FRAME_COUNT and its counter; other behaviour identical.

Verification (P_COLUMNS=4, P_IMAGE_ROWS=4 unless stated)
REQ-036 SHALL cover: reset, I_PIXEL_VALID=1, pixels 0x00.. -> first 8 pixels write only, slots 0,0,0,0,1,1,1,1; no O_MATRIX_VALID.
REQ-037 SHALL cover: pixel (2,1) -> write slot 2 col 1, next cycle read slot 1 col 0, next cycle O_MATRIX_VALID, centre (1,0), O_BORDER=1.
REQ-038 SHALL cover: pixel (2,3) -> reads col 2 then col 3 back-to-back, two valids, centres (1,2) O_BORDER=0 and (1,3) O_BORDER=1.
REQ-039 SHALL cover: full frame -> 8 valids, one O_FRAME_DONE after pixel (3,3); next pixel writes slot 0 col 0; O_FRAME_COUNT=1 when macro defined.
REQ-040 SHALL cover: I_PIXEL_VALID toggled randomly -> identical write/read sequence, no strobe without handshake, never both enables high.
REQ-041 SHALL cover: I_RESET asserted in S_READ -> no valid next cycle; after release pixel 0x55 writes slot 0 col 0.
